mem_port_arbiter: RTL and testbench

//   Shares one port of the 32K x 16 dual-port block memory between NUM_REQ requesters
//   (e.g. CPU data access, VGA fetch, DMA). Picks one request per cycle and drives the

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 78 +++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants and the response-tag type for mem_port_arbiter.
// Contents: default memory geometry, memory read latency, and rsp_tag_t
// (valid bit plus granted requester index).
package mem_arb_pkg;
   localparam int MEM_ADDR_W     = 15;
   localparam int MEM_DATA_W     = 16;
   localparam int MEM_RD_LATENCY = 1;
   // Index field sized for the largest supported NUM_REQ (8).
   localparam int TAG_IDX_W      = 3;
   typedef struct packed {
      logic                 vld;
      logic [TAG_IDX_W-1:0] idx;
   } rsp_tag_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational one-hot pick of the first eligible requester,
// searching upward from ptr and wrapping at N.
// Ports: eligible (N candidate mask), ptr (search start), pick (one-hot winner),
// idx (winner index), any (a winner exists).
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  eligible,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx,
   output logic          any
);
   always_comb begin
      pick = '0;
      idx  = '0;
      any  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!any && eligible[(int'(ptr) + k) % N]) begin
            pick[(int'(ptr) + k) % N] = 1'b1;
            idx = IW'((int'(ptr) + k) % N);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between NUM_REQ requesters,
// issuing at most one access per cycle and returning read data / write-ack
// MEM_RD_LATENCY cycle after issue.
// Ports: clk, reset_n (async, active low); req/req_we/req_addr/req_wdata per requester;
// gnt (one-hot issue pulse); rsp_valid/rsp_rdata (one-hot response + shared data);
// mem_addr/mem_we/mem_wdata (registered to memory); mem_rdata (from memory); busy.
// Config: define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins);
// default is round-robin.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_we,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [NUM_REQ-1:0]   win;
   logic [IW-1:0]        win_idx;
   logic [IW-1:0]        ptr;
   logic                 win_any;
   logic [TAG_IDX_W-1:0] iss_idx;
   rsp_tag_t             tag;
`ifdef MEM_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ptr <= '0;
      else if (win_any) ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   end
`endif
   // Masking by the current gnt stops a held req from winning twice in a row.
   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .eligible(req & ~gnt),
      .ptr     (ptr),
      .pick    (win),
      .idx     (win_idx),
      .any     (win_any)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt       <= '0;
         iss_idx   <= '0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         tag       <= '0;
      end else begin
         gnt     <= win;
         iss_idx <= TAG_IDX_W'(win_idx);
         mem_we  <= win_any & req_we[win_idx];
         if (win_any) begin
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
         end
         // The issue-stage tag advances while the memory performs its read.
         tag <= '{vld: |gnt, idx: iss_idx};
      end
   end
   // Memory output is valid in the response cycle, so the data path is combinational.
   assign rsp_valid = tag.vld ? NUM_REQ'(1) << tag.idx : '0;
   assign rsp_rdata = tag.vld ? mem_rdata : '0;
   assign busy      = |gnt | |rsp_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized bench for mem_port_arbiter (NUM_REQ=4)
// against a cycle-level reference model and a write-first synchronous memory.
module tb_mem_port_arbiter;
   localparam int N = 4, AW = 15, DW = 16;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [N-1:0]    req, req_we, gnt, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0]   mem_addr;
   logic            mem_we, busy;
   logic [DW-1:0]   mem [0:32767];
   logic            pl_en = 1'b0;
   logic [AW-1:0]   pl_addr = '0;
   logic [DW-1:0]   pl_data = '0;
   logic [DW-1:0]   ref_mem [0:32767];
   int              m_ptr, m_iss_idx, m_rsp_idx;
   logic [N-1:0]    m_gnt;
   logic            m_we, m_iss_v, m_rsp_v;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata, m_iss_data, m_rsp_data;
   int              n_chk = 0, n_pass = 0, we_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem_we ? mem_wdata : mem[mem_addr];
   end

   mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_ptr = 0; m_gnt = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      m_iss_v = 1'b0; m_iss_idx = 0; m_iss_data = '0;
      m_rsp_v = 1'b0; m_rsp_idx = 0; m_rsp_data = '0;
   endtask

   // One clock of the reference: responses trail issues by one cycle, and data is
   // resolved at issue time against a memory updated strictly in grant order.
   task automatic model_update();
      int w, start;
      m_rsp_v = m_iss_v; m_rsp_idx = m_iss_idx; m_rsp_data = m_iss_data;
`ifdef MEM_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = m_ptr;
`endif
      w = -1;
      for (int k = 0; k < N; k++)
         if (w < 0 && req[(start + k) % N] && !m_gnt[(start + k) % N]) w = (start + k) % N;
      m_gnt = '0; m_we = 1'b0; m_iss_v = (w >= 0);
      if (w >= 0) begin
         m_gnt[w] = 1'b1; m_ptr = (w + 1) % N; m_iss_idx = w;
         m_we = req_we[w]; m_addr = req_addr[w*AW +: AW]; m_wdata = req_wdata[w*DW +: DW];
         if (m_we) begin ref_mem[m_addr] = m_wdata; m_iss_data = m_wdata; end
         else m_iss_data = ref_mem[m_addr];
      end
   endtask

   task automatic compare();
      check("gnt", 64'(gnt), 64'(m_gnt));
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v ? 4'(4'b1 << m_rsp_idx) : 4'b0));
      check("mem_we", 64'(mem_we), 64'(m_we));
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("busy", 64'(busy), 64'((|m_gnt) | m_rsp_v));
      if (m_rsp_v) check("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_data));
      if (m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
   endtask

   task automatic step();
      @(posedge clk); #1;
      model_update();
      compare();
      if (mem_we) we_cnt++;
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i] = 1'b1; req_we[i] = we; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
   endtask

   task automatic preload(input int a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = AW'(a); pl_data = d; ref_mem[a] = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   initial begin
      logic [1:0] prev;
      logic       g2;
      logic [N-1:0] e1, e2;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      model_reset();
      for (int a = 0; a < 8; a++) preload(a, DW'(a * 16'h1111));
      preload(16'h0010, 16'hBEEF);
      preload(16'h7FFF, 16'h0000);
      check("rst_gnt", 64'(gnt), 0);
      check("rst_busy", 64'(busy), 0);
      reset_n = 1'b1;

      // reset in the middle of an access
      set_req(0, 1'b0, 15'h0010, '0);
      step();
      req = '0;
      reset_n = 1'b0; #1;
      check("arst_gnt", 64'(gnt), 0);
      check("arst_rsp_valid", 64'(rsp_valid), 0);
      check("arst_mem_we", 64'(mem_we), 0);
      check("arst_busy", 64'(busy), 0);
      check("arst_mem_addr", 64'(mem_addr), 0);
      check("arst_mem_wdata", 64'(mem_wdata), 0);
      check("arst_rsp_rdata", 64'(rsp_rdata), 0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("arst_no_rsp", 64'(rsp_valid), 0);
      end

      // single read
      set_req(0, 1'b0, 15'h0010, '0);
      step();
      check("rd_gnt", 64'(gnt), 64'h1);
      check("rd_addr", 64'(mem_addr), 64'h0010);
      req = '0;
      step();
      check("rd_rsp_valid", 64'(rsp_valid), 64'h1);
      check("rd_rdata", 64'(rsp_rdata), 64'hBEEF);

      // write then read of the same address by one requester
      we_cnt = 0;
      set_req(1, 1'b1, 15'h7FFF, 16'h1234);
      step();
      check("wr_gnt", 64'(gnt), 64'h2);
      set_req(1, 1'b0, 15'h7FFF, '0);
      step();
      check("wr_rsp_valid", 64'(rsp_valid), 64'h2);
      check("wr_rdata", 64'(rsp_rdata), 64'h1234);
      step();
      check("rbw_gnt", 64'(gnt), 64'h2);
      req = '0;
      step();
      check("rbw_rdata", 64'(rsp_rdata), 64'h1234);
      step();
      check("wr_we_cycles", 64'(we_cnt), 1);

      // two requesters contending
      set_req(0, 1'b0, 15'h0001, '0);
      set_req(1, 1'b0, 15'h0002, '0);
      prev = 2'b00;
      for (int c = 0; c < 8; c++) begin
         step();
         check("cont_gnt", 64'(gnt[1:0]), 64'((c % 2 == 0) ? 2'b01 : 2'b10));
         if (c > 0) check("cont_rsp", 64'(rsp_valid[1:0]), 64'(prev));
         prev = gnt[1:0];
      end
      req = '0;
      step(); step();

      // pointer wrap and a withdrawn request
      set_req(2, 1'b0, 15'h0003, '0);
      step();
      req = '0;
      step();
`ifdef MEM_ARB_FIXED_PRIO_EN
      e1 = 4'b0001; e2 = 4'b1000;
`else
      e1 = 4'b1000; e2 = 4'b0001;
`endif
      set_req(0, 1'b0, 15'h0004, '0);
      set_req(2, 1'b0, 15'h0005, '0);
      set_req(3, 1'b0, 15'h0006, '0);
      step();
      g2 = gnt[2] | rsp_valid[2];
      check("wrap_gnt_a", 64'(gnt), 64'(e1));
      req[2] = 1'b0;
      step();
      g2 |= gnt[2] | rsp_valid[2];
      check("wrap_gnt_b", 64'(gnt), 64'(e2));
      req = '0;
      for (int c = 0; c < 3; c++) begin
         step();
         g2 |= gnt[2] | rsp_valid[2];
      end
      check("withdraw_never", 64'(g2), 0);

      // randomized traffic on a small address window to provoke hazards
      for (int c = 0; c < 500; c++) begin
         step();
         for (int i = 0; i < N; i++) begin
            if (req[i] && !m_gnt[i]) begin
               if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
               set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            end else begin
               req[i] = 1'b0;
            end
         end
      end
      req = '0;
      for (int c = 0; c < 3; c++) step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
